// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the pipeline hazard controller.
//   - FWD_*      : operand-forwarding select encodings used on the Forward bus
//   - hz_state_t : state of the multi-cycle-operation busy FSM
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Forward select encodings, one 2-bit field per EX source operand.
    localparam logic [1:0] FWD_RF  = 2'b00;  // operand comes from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // bypass from the WB stage write data
    localparam logic [1:0] FWD_MEM = 2'b10;  // bypass from the MEM stage ALU result

    // Busy FSM: IDLE lets instructions flow, BUSY holds a multi-cycle op in EX.
    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
//   Forwarding select for a single EX source operand. A stage only forwards
//   when it actually writes the register file and its destination is not x0.
//   The younger MEM stage wins over WB when both hold the register.
//
//   Ports
//     rs            in  AW  source register of the EX operand
//     rd_mem        in  AW  destination register in MEM
//     rd_wb         in  AW  destination register in WB
//     reg_write_mem in  1   MEM instruction writes the register file
//     reg_write_wb  in  1   WB instruction writes the register file
//     fwd           out 2   FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rd_mem,
    input  logic [AW-1:0] rd_wb,
    input  logic          reg_write_mem,
    input  logic          reg_write_wb,
    output logic [1:0]    fwd
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = reg_write_mem && (rd_mem != '0) && (rs == rd_mem);
    assign wb_hit  = reg_write_wb  && (rd_wb  != '0) && (rs == rd_wb);

    always_comb begin
        fwd = FWD_RF;
        if (mem_hit) begin
            fwd = FWD_MEM;
        end else if (wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Hazard controller for the 5-stage pipeline: MEM/WB operand forwarding,
//   load-use stall detection, a busy FSM that keeps a multi-cycle ALU op in EX
//   for MC_LAT cycles, branch flushes and a saturating stall-cycle counter.
//
//   Parameters
//     AW      register-address width
//     NSRC    source operands per instruction (1..4)
//     MC_LAT  total EX occupancy of a multi-cycle op in cycles (>= 2)
//     CW      stall-counter width
//
//   Ports
//     CLK, RST           clock, asynchronous active-high reset
//     Rs_ID, Rs_used_ID  sources of the ID instruction and which are read
//     Rs_EX              sources of the EX instruction
//     Rd_EX/MEM/WB       destinations in EX, MEM, WB
//     MemRead_EX         EX instruction is a load
//     RegWrite_MEM/WB    MEM / WB instruction writes the register file
//     MC_start_EX        EX instruction is a multi-cycle op
//     Branch_taken_EX    taken branch/jump resolved in EX
//     Cnt_clr            synchronous clear of Stall_count
//     Forward            per-operand forwarding select, 2 bits each
//     Stall_front        hold PC and IF/ID
//     Flush_front        IF/ID loads a NOP
//     Bubble_EX          ID/EX loads a NOP
//     Hold_EX            ID/EX keeps its contents
//     Bubble_MEM         EX/MEM loads a NOP
//     MC_done            pulse in the final cycle of a multi-cycle op
//     Busy               FSM is in BUSY
//     Stall_count        saturating count of Stall_front cycles
//   All control outputs are combinational; every output reads 0 while RST=1.
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int MC_LAT = 4,
    parameter int CW     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NSRC*AW-1:0]   Rs_ID,
    input  logic [NSRC-1:0]      Rs_used_ID,
    input  logic [NSRC*AW-1:0]   Rs_EX,
    input  logic [AW-1:0]        Rd_EX,
    input  logic [AW-1:0]        Rd_MEM,
    input  logic [AW-1:0]        Rd_WB,
    input  logic                 MemRead_EX,
    input  logic                 RegWrite_MEM,
    input  logic                 RegWrite_WB,
    input  logic                 MC_start_EX,
    input  logic                 Branch_taken_EX,
    input  logic                 Cnt_clr,
    output logic [2*NSRC-1:0]    Forward,
    output logic                 Stall_front,
    output logic                 Flush_front,
    output logic                 Bubble_EX,
    output logic                 Hold_EX,
    output logic                 Bubble_MEM,
    output logic                 MC_done,
    output logic                 Busy,
    output logic [CW-1:0]        Stall_count
);

    localparam int              CNTW     = $clog2(MC_LAT);
    // The start cycle is the first of MC_LAT, and the cycle with cnt==0 is
    // the last, so BUSY is entered with MC_LAT-2 cycles still to hold.
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MC_LAT - 2);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    hz_state_t         state_reg;
    hz_state_t         state_next;
    logic [CNTW-1:0]   cnt_reg;
    logic [CNTW-1:0]   cnt_next;
    logic [CW-1:0]     stall_count_reg;
    logic [CW-1:0]     stall_count_next;

    logic [2*NSRC-1:0] fwd_raw;
    logic [NSRC-1:0]   lu_hit;

    logic is_busy;
    logic is_last;
    logic mc_hold;
    logic branch_act;
    logic load_use;
    logic lu_act;
    logic stall_raw;

    // ------------------------------------------------------------------
    // Per-operand forwarding and load-use compare
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            fwd_sel #(
                .AW (AW)
            ) u_fwd_sel (
                .rs            (Rs_EX[gi*AW +: AW]),
                .rd_mem        (Rd_MEM),
                .rd_wb         (Rd_WB),
                .reg_write_mem (RegWrite_MEM),
                .reg_write_wb  (RegWrite_WB),
                .fwd           (fwd_raw[2*gi +: 2])
            );

            assign lu_hit[gi] = Rs_used_ID[gi] && (Rs_ID[gi*AW +: AW] == Rd_EX);
        end
    endgenerate

    // A load into x0 never creates a dependency.
    assign load_use = MemRead_EX && (Rd_EX != '0) && (|lu_hit);

    // ------------------------------------------------------------------
    // Stall / flush decisions
    // ------------------------------------------------------------------
    assign is_busy = (state_reg == HZ_BUSY);
    assign is_last = is_busy && (cnt_reg == '0);

    // The multi-cycle op holds EX from its start cycle until the cycle
    // before its last; in the last cycle the pipeline is released again.
    assign mc_hold = (!is_busy && MC_start_EX) || (is_busy && !is_last);

    // Branches are only honoured when EX is not being held; a start in the
    // same IDLE cycle takes precedence because mc_hold is already high.
    assign branch_act = Branch_taken_EX && !mc_hold;

    // Load-use only acts when EX is free to advance and no branch flushes
    // the offending instruction away anyway.
    assign lu_act = load_use && !mc_hold && !branch_act;

    assign stall_raw = mc_hold || lu_act;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HZ_IDLE: begin
                if (MC_start_EX) begin
                    state_next = HZ_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            HZ_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = HZ_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = HZ_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (Cnt_clr) begin
            stall_count_next = '0;
        end else if (stall_raw && (stall_count_reg != CNT_MAX)) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= HZ_IDLE;
            cnt_reg         <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all forced low while reset is applied
    // ------------------------------------------------------------------
    assign Forward     = RST ? '0 : fwd_raw;
    assign Stall_front = !RST && stall_raw;
    assign Flush_front = !RST && branch_act;
    assign Bubble_EX   = !RST && (branch_act || lu_act);
    assign Hold_EX     = !RST && mc_hold;
    assign Bubble_MEM  = !RST && mc_hold;
    assign MC_done     = !RST && is_last;
    assign Busy        = !RST && is_busy;
    assign Stall_count = stall_count_reg;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It computes MEM/WB operand forwarding for NSRC source operands in EX and detects load-use hazards against the instruction in ID. It also runs a busy FSM that holds a multi-cycle ALU operation in EX for MC_LAT cycles, applies branch flushes, and keeps a saturating stall-cycle counter. It sits beside the ID/EX, EX/MEM and IF/ID pipeline registers and drives their hold/bubble controls.

## Interface
- AW, 5: register-address width.
- NSRC, 2: source operands per instruction (1..4).
- MC_LAT, 4: total EX occupancy in cycles of a multi-cycle op (≥2).
- CW, 16: stall-counter width.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Rs_ID  in  NSRC*AW  sources of instruction in ID; operand i at [i*AW +: AW].
- Rs_used_ID  in  NSRC  operand i of ID instruction is actually read.
- Rs_EX  in  NSRC*AW  sources of instruction in EX.
- Rd_EX, Rd_MEM, Rd_WB  in  AW each  destinations in EX/MEM/WB.
- MemRead_EX  in  1  EX instruction is a load.
- RegWrite_MEM, RegWrite_WB  in  1 each  stage writes the register file.
- MC_start_EX  in  1  EX instruction is a multi-cycle op.
- Branch_taken_EX  in  1  taken branch/jump resolved in EX.
- Cnt_clr  in  1  synchronous clear of Stall_count.
- Forward  out  2*NSRC  per-operand select; 00 = register file, 01 = WB data, 10 = MEM ALU result.
- Stall_front  out  1  hold PC and IF/ID.
- Flush_front  out  1  IF/ID loads NOP.
- Bubble_EX  out  1  ID/EX loads NOP.
- Hold_EX  out  1  ID/EX holds its contents.
- Bubble_MEM  out  1  EX/MEM loads NOP.
- MC_done  out  1  one-cycle pulse in the final cycle of a multi-cycle op.
- Busy  out  1  FSM in BUSY.
- Stall_count  out  CW  cycles with Stall_front=1, saturating.

## Operation
- Forwarding is combinational and independent per operand i:
  - MEM match (RegWrite_MEM, Rd_MEM≠0, Rs_EX[i]==Rd_MEM) gives 10.
  - Otherwise a WB match under the same rule gives 01.
  - Otherwise 00.
  - MEM has priority when both stages match.
- Load-use hazard: MemRead_EX and Rd_EX≠0 and some i with Rs_used_ID[i] and Rs_ID[i]==Rd_EX.
  - Response: Stall_front=1, Bubble_EX=1.
- FSM states are IDLE and BUSY, with down-counter cnt of width $clog2(MC_LAT).
- IDLE:
  - MC_start_EX=1 gives Stall_front=Hold_EX=Bubble_MEM=1 this cycle; next state BUSY, cnt←MC_LAT-2.
  - Otherwise the load-use and branch rules apply.
- BUSY, cnt≠0: Stall_front=Hold_EX=Bubble_MEM=1; cnt decrements. MC_start_EX and Branch_taken_EX are ignored.
- BUSY, cnt==0:
  - Stall/hold/bubble released; MC_done=1; next state IDLE.
  - The load-use rule is evaluated normally this cycle.
  - MC_start_EX is ignored, because the same op is still present.
- Branch_taken_EX (IDLE, or BUSY with cnt==0): Flush_front=1, Bubble_EX=1, Stall_front forced 0.
  - A branch overrides a simultaneous load-use hazard.
  - MC_start_EX and Branch_taken_EX together in IDLE: MC_start_EX wins and the branch is ignored. Decode never produces this combination.
- The multi-cycle unit latches its operands in the MC_start cycle. Forward values during BUSY are still computed but are don't-care.
- Stall_count increments each cycle Stall_front=1 and holds at 2^CW-1.
  - Cnt_clr has priority and loads 0.
  - If Cnt_clr and a stall occur in the same cycle, the result is 0.

## Timing
- Forward, Stall_front, Flush_front, Bubble_EX, Hold_EX, Bubble_MEM and MC_done are combinational from inputs and state; zero registered latency.
- A multi-cycle op starting in cycle t:
  - Stalls cycles t..t+MC_LAT-2, i.e. MC_LAT-1 stall cycles.
  - MC_done is asserted at t+MC_LAT-1.
  - The op leaves EX at the end of t+MC_LAT-1.
- Busy goes high at t+1 and low at t+MC_LAT.
- Reset, asynchronous and active-high: state=IDLE, cnt=0, Stall_count=0.
  - While RST=1, every output is forced to 0, including Forward.
- Reset asserted mid-BUSY aborts the op. The first cycle after release is IDLE.

## Structure
- Package hazard_pkg holds:
  - Forward encoding constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The FSM enum hz_state_t {HZ_IDLE, HZ_BUSY}.
- Sub-module fwd_sel: one operand's MEM/WB compare, instantiated NSRC times via generate.
- FSM, counter and hazard logic stay in hazard_unit.

## Test plan
- Rs_EX[0]=5, Rd_MEM=5, RegWrite_MEM=1, Rd_WB=5, RegWrite_WB=1 -> Forward[1:0]=10. Then drop RegWrite_MEM -> 01. Then set Rd_MEM=Rd_WB=0 -> 00.
- Load-use: MemRead_EX=1, Rd_EX=7, Rs_ID[1]=7, Rs_used_ID=2'b10 -> Stall_front=Bubble_EX=1, Stall_count +1. Same with Rs_used_ID=2'b01 -> no stall.
- MC_LAT=4, MC_start_EX=1 held:
  - Stall/Hold_EX/Bubble_MEM high for 3 cycles.
  - MC_done high in the 4th cycle only, with Busy high in cycles 2-4.
  - FSM back in IDLE; MC_start not re-triggered.
- Branch_taken_EX=1 with a simultaneous load-use hazard -> Flush_front=Bubble_EX=1, Stall_front=0.
- RST asserted during BUSY with cnt=1 -> all outputs 0 immediately. After release, Busy=0 and Stall_count=0.
- 2^CW+3 consecutive load-use stalls -> Stall_count saturates at 2^CW-1. Cnt_clr=1 -> 0 the next cycle.
